// File: rtl/kb_pkg.sv
// kb_pkg: shared scan-code constants and FSM encodings for the keyboard front end
package kb_pkg;
  localparam logic [7:0] BRK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE = 8'hE0;
  localparam int FRAME_BITS = 11;
  typedef enum logic [1:0] {RX_IDLE, RX_DPS, RX_LOAD} rx_state_t;
  typedef enum logic {WAIT_BRK, GET_CODE} scan_state_t;
endpackage

// File: rtl/kb_scan_decoder_if.sv
// kb_scan_decoder_if: read-side handshake and status between the decoder and its consumers
interface kb_scan_decoder_if;
  logic       rd_key_code;
  logic [7:0] key_code;
  logic       kb_buf_empty;
  logic       kb_buf_full;
  logic       frame_err;
  logic       overflow;
  modport master(output rd_key_code, input key_code, kb_buf_empty, kb_buf_full, frame_err, overflow);
  modport slave(input rd_key_code, output key_code, kb_buf_empty, kb_buf_full, frame_err, overflow);
endinterface

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: conditions raw PS/2 lines and deframes 11-bit frames into checked bytes
module ps2_frame_rx
  import kb_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2d,
  input  logic       ps2c,
  output logic       byte_tick,
  output logic [7:0] rx_byte,
  output logic       frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  rx_state_t state, state_next;
  logic [1:0] d_sync;
  logic [FILTER_LEN-1:0] c_shift;
  logic c_filt, fall_tick, timeout, par_ok;
  logic [3:0] n;
  logic [FRAME_BITS-2:0] sr;
  logic [TW-1:0] t_cnt;
  assign fall_tick = c_filt && c_shift == '0;
  assign timeout = state == RX_DPS && !fall_tick && t_cnt == TW'(TIMEOUT_CYC - 1);
  assign par_ok = ^sr[8:0] && sr[9];
  always_ff @(posedge clk) state <= reset ? RX_IDLE : state_next;
  // sr collects start..stop LSB-first; the start bit is shifted out by the time the stop bit lands
  always_ff @(posedge clk) begin
    if (reset) begin
      d_sync <= 2'b11;
      c_shift <= '1;
      c_filt <= 1'b1;
      n <= '0;
      sr <= '0;
      t_cnt <= '0;
    end else begin
      d_sync <= {d_sync[0], ps2d};
      c_shift <= {c_shift[FILTER_LEN-2:0], ps2c};
      c_filt <= &c_shift ? 1'b1 : (c_shift == '0 ? 1'b0 : c_filt);
      t_cnt <= (state == RX_DPS && !fall_tick) ? t_cnt + 1'b1 : '0;
      if (fall_tick) begin
        sr <= {d_sync[1], sr[FRAME_BITS-2:1]};
        n <= state == RX_IDLE ? 4'(FRAME_BITS - 2) : n - 1'b1;
      end
    end
  end
  always_comb begin
    state_next = state == RX_IDLE ? (fall_tick && !d_sync[1] ? RX_DPS : RX_IDLE) :
                 state == RX_DPS  ? (timeout ? RX_IDLE : (fall_tick && n == '0 ? RX_LOAD : RX_DPS)) :
                 RX_IDLE;
  end
  always_comb begin
    byte_tick = state == RX_LOAD && par_ok;
    frame_err = (state == RX_LOAD && !par_ok) || timeout;
    rx_byte = sr[7:0];
  end
endmodule

// File: rtl/kb_scan_decoder.sv
// kb_scan_decoder: keeps key-release codes from PS/2 frames and queues them in a FWFT FIFO
module kb_scan_decoder
  import kb_pkg::*;
#(
  parameter int W_SIZE      = 2,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input logic clk,
  input logic reset,
  input logic ps2d,
  input logic ps2c,
  kb_scan_decoder_if.slave kb
);
  localparam int DEPTH = 2 ** W_SIZE;
  scan_state_t scan, scan_next;
  logic byte_tick, push, pop, wr_en;
  logic [7:0] rx_byte;
  logic [7:0] mem [DEPTH];
  logic [W_SIZE-1:0] wr_ptr, rd_ptr;
  logic [W_SIZE:0] count;
  ps2_frame_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c),
    .byte_tick(byte_tick), .rx_byte(rx_byte), .frame_err(kb.frame_err)
  );
  always_ff @(posedge clk) scan <= reset ? WAIT_BRK : scan_next;
  // E0 inside a release (E0 F0 xx) keeps us waiting for the real code
  always_comb begin
    scan_next = !byte_tick ? scan :
                scan == WAIT_BRK ? (rx_byte == BRK_CODE ? GET_CODE : WAIT_BRK) :
                (rx_byte == EXT_CODE ? GET_CODE : WAIT_BRK);
  end
  always_comb push = byte_tick && scan == GET_CODE && rx_byte != EXT_CODE;
  assign pop = kb.rd_key_code && !kb.kb_buf_empty;
  assign wr_en = push && (!kb.kb_buf_full || pop);
  always_ff @(posedge clk) begin
    if (reset) begin
      mem <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      kb.overflow <= 1'b0;
    end else begin
      if (wr_en) mem[wr_ptr] <= rx_byte;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (W_SIZE + 1)'(wr_en) - (W_SIZE + 1)'(pop);
      if (push && !wr_en) kb.overflow <= 1'b1;
    end
  end
  assign kb.kb_buf_empty = count == '0;
  assign kb.kb_buf_full = count == (W_SIZE + 1)'(DEPTH);
  assign kb.key_code = mem[rd_ptr];
endmodule

// File: tb/tb_kb_scan_decoder.sv
// tb_kb_scan_decoder: directed and randomized PS/2 frames checked against a release-code queue model
module tb_kb_scan_decoder;
  localparam int W_SIZE = 2, FILTER_LEN = 8, TIMEOUT_CYC = 2000, DEPTH = 4;
  logic clk = 0, reset = 1, ps2d = 1, ps2c = 1;
  kb_scan_decoder_if kb();
  kb_scan_decoder #(.W_SIZE(W_SIZE), .FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .reset(reset), .ps2d(ps2d), .ps2c(ps2c), .kb(kb)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0, err_seen = 0, exp_err = 0;
  logic [7:0] q[$];
  bit after_brk = 0, ovf = 0;
  always @(negedge clk) if (kb.frame_err === 1'b1) err_seen++;
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(int k);
    repeat (k) @(negedge clk);
  endtask
  function automatic void model(logic [7:0] b);
    if (!after_brk) after_brk = (b == 8'hF0);
    else if (b != 8'hE0) begin
      after_brk = 0;
      if (q.size() < DEPTH) q.push_back(b);
      else ovf = 1;
    end
  endfunction
  task automatic send_bit(logic b);
    ps2d = b; tick(4);
    ps2c = 0; tick(12);
    ps2c = 1; tick(12);
  endtask
  task automatic send_frame(logic [7:0] b, bit bad = 0);
    send_bit(0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~^b ^ bad);
    send_bit(1);
    if (bad) exp_err++;
    else model(b);
  endtask
  task automatic read_one(string tag);
    check({tag, "_empty"}, kb.kb_buf_empty, q.size() == 0);
    if (q.size() != 0) begin
      check({tag, "_code"}, kb.key_code, q[0]);
      void'(q.pop_front());
    end
    kb.rd_key_code = 1; tick(1); kb.rd_key_code = 0;
  endtask
  task automatic drain(string tag);
    while (q.size() != 0) read_one(tag);
    check({tag, "_drained"}, kb.kb_buf_empty, 1);
  endtask
  task automatic check_reset(string tag);
    check({tag, "_empty"}, kb.kb_buf_empty, 1);
    check({tag, "_full"}, kb.kb_buf_full, 0);
    check({tag, "_ovf"}, kb.overflow, 0);
    check({tag, "_ferr"}, kb.frame_err, 0);
    check({tag, "_code"}, kb.key_code, 8'h00);
  endtask
  initial begin
    logic [7:0] b;
    int r;
    kb.rd_key_code = 0;
    tick(3);
    check_reset("rst");
    reset = 0; tick(2);
    send_frame(8'h1C); send_frame(8'hF0);
    check("a_pre_empty", kb.kb_buf_empty, 1);
    send_frame(8'h1C);
    check("a_ready", kb.kb_buf_empty, 0);
    read_one("a");
    check("a_after_read", kb.kb_buf_empty, 1);
    send_frame(8'hE0); send_frame(8'h75); send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
    drain("ext");
    send_frame(8'h1C); send_frame(8'h1C); send_frame(8'h1C); send_frame(8'hF0); send_frame(8'h1C);
    drain("typ");
    send_frame(8'hF0, 1); send_frame(8'h1C);
    check("par_ferr", err_seen, exp_err);
    check("par_empty", kb.kb_buf_empty, 1);
    send_bit(0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    tick(TIMEOUT_CYC + 50);
    exp_err++;
    check("to_ferr", err_seen, exp_err);
    send_frame(8'hF0); send_frame(8'h2B);
    drain("to");
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'hF0); send_frame(8'(i));
    end
    check("ovf_full", kb.kb_buf_full, 1);
    check("ovf_flag", kb.overflow, 1);
    check("ovf_model", kb.overflow, ovf);
    drain("ovf");
    ps2d = 0; tick(4);
    ps2c = 0; tick(3);
    ps2c = 1; tick(20);
    ps2d = 1; tick(4);
    send_frame(8'hF0); send_frame(8'h33);
    drain("glitch");
    read_one("empty_rd");
    send_frame(8'hF0); send_frame(8'h44);
    drain("post_empty_rd");
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 3);
      b = r == 0 ? 8'hF0 : r == 1 ? 8'hE0 : 8'($urandom);
      send_frame(b, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) read_one("rnd");
    end
    check("rnd_ferr", err_seen, exp_err);
    check("rnd_ovf", kb.overflow, ovf);
    drain("rnd");
    send_frame(8'hF0); send_frame(8'h11);
    send_bit(0); send_bit(1); send_bit(0);
    reset = 1; tick(1);
    check_reset("mid");
    reset = 0; q.delete(); after_brk = 0; ovf = 0; tick(2);
    send_frame(8'hF0); send_frame(8'h22);
    drain("after_rst");
    check("final_ferr", err_seen, exp_err);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/kb_scan_decoder.md
Name: kb_scan_decoder

Overview:
Upstream keyboard front end. Receives raw PS/2 frames from the keyboard and keeps only key-release make codes: a byte that follows the F0 break prefix. Those codes are buffered in a FIFO for the key-to-ASCII and UART stages. Exposes the same read-side handshake those stages already use: rd_key_code, key_code and kb_buf_empty.

Parameters:
W_SIZE, 2, FIFO address width; depth = 2**W_SIZE entries of 8 bits.
FILTER_LEN, 8, ps2c glitch-filter length in clk samples.
TIMEOUT_CYC, 200000, clk cycles without a filtered ps2c falling edge before an in-progress frame is abandoned (2 ms at 100 MHz).

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
ps2d  in  1  PS/2 data line, asynchronous
ps2c  in  1  PS/2 clock line, asynchronous
rd_key_code  in  1  pop request; one FIFO entry per high cycle
key_code  out  8  FIFO head, first-word-fall-through; valid when kb_buf_empty=0
kb_buf_empty  out  1  FIFO empty
kb_buf_full  out  1  FIFO full
frame_err  out  1  one-cycle pulse on parity/stop error or timeout
overflow  out  1  sticky; set when a code is dropped because the FIFO is full; cleared only by reset

Behaviour:
- Reset values (synchronous, next clk edge with reset=1):
  - kb_buf_empty=1, kb_buf_full=0, frame_err=0, overflow=0, key_code=8'h00.
  - Filter shift register all ones; filtered ps2c=1.
  - Both FSMs in idle. FIFO pointers 0. Timeout counter 0.
  - Reset mid-frame discards the partial frame and all FIFO contents.
- Input conditioning:
  - ps2d passes through a 2-flop synchronizer.
  - ps2c is sampled into a FILTER_LEN shift register. Filtered ps2c becomes 1 when all samples are 1, becomes 0 when all samples are 0, and otherwise holds.
  - fall_tick is a one-cycle pulse when filtered ps2c goes 1->0.
- Frame FSM (in ps2_frame_rx): states IDLE, DPS, LOAD.
  - IDLE: on fall_tick with synced ps2d=0 (start bit), go to DPS with bit counter=9. fall_tick with ps2d=1 is ignored.
  - DPS: on each fall_tick, shift ps2d in LSB-first (8 data bits, odd parity, stop). When the counter reaches 0 after the stop bit, go to LOAD.
  - LOAD: for one cycle, check odd parity over data+parity and stop=1. Pass -> byte_tick for one cycle with the byte; fail -> frame_err pulse. Return to IDLE.
  - Timeout counter runs in DPS, clears on each fall_tick, and leaves IDLE clearing it. Reaching TIMEOUT_CYC-1 -> frame_err pulse, go to IDLE, no byte.
- Scan FSM: states WAIT_BRK, GET_CODE.
  - WAIT_BRK: byte F0 -> GET_CODE. All other bytes (make codes, E0, typematic repeats) are discarded.
  - GET_CODE: the next valid byte is pushed to the FIFO, then return to WAIT_BRK. If that byte is E0, stay in GET_CODE and do not push (extended release is E0 F0 xx, so E0 F0 xx pushes xx).
  - A frame error does not change scan state.
- FIFO:
  - Push happens in the byte_tick cycle. kb_buf_empty falls on the next edge, so the code is readable 1 cycle after LOAD.
  - Push when full and no pop: drop the code, set overflow.
  - Push and pop in the same cycle when full: both happen; count unchanged.
  - Push and pop in the same cycle when empty: the pop is ignored and the push is accepted.
  - rd_key_code while empty is ignored; pointers do not move.
  - Pointers wrap modulo 2**W_SIZE.
  - key_code = mem[rd_ptr] and changes the cycle after a pop. When empty, key_code is undefined-stable (last value); checkers must not compare it.

Decomposition:
- Shared package kb_pkg holds:
  - BRK_CODE=8'hF0, EXT_CODE=8'hE0
  - FRAME_BITS=11
  - state encodings for the frame FSM and scan FSM
- Sub-module ps2_frame_rx holds the synchronizer, filter, edge detect, frame FSM and timeout, and outputs byte_tick, byte and frame_err.
- Scan FSM and FIFO live in the top.

Test Plan:
- Press/release of 'A': frames 1C, F0, 1C with valid parity -> exactly one entry key_code=8'h1C. kb_buf_empty low 1 cycle after the final LOAD; rd_key_code pulse -> empty again.
- Extended release: E0 75, E0 F0 75 -> single entry 8'h75. Typematic 1C 1C 1C before F0 1C -> still one entry.
- Parity error: F0 sent with even parity, then 1C -> frame_err pulses once, FIFO stays empty, scan FSM stays in WAIT_BRK.
- Timeout: start bit plus 4 data bits, then ps2c held high for TIMEOUT_CYC cycles -> frame_err pulse. A following clean F0 2B pushes 8'h2B.
- Overflow with W_SIZE=2: five release sequences (codes 01..05), no reads -> kb_buf_full=1, overflow=1. Four reads return 01,02,03,04 in order.
- Glitch and empty read:
  - 3-cycle low glitch on ps2c with FILTER_LEN=8 -> no fall_tick, no state change.
  - rd_key_code while empty -> pointers unchanged.
  - Reset asserted mid-frame -> all outputs back to reset values at the next clk edge.
